// File: rtl/router_pkg.sv
// Shared constants, assembly state encoding and header check for the Aurora RX
// packet assembler.
package router_pkg;

  localparam int AURORA_DATA_WIDTH = 64;
  localparam int NUMBER_PACKET     = 19;
  localparam int PKT_WIDTH         = NUMBER_PACKET * AURORA_DATA_WIDTH;
  localparam int CNT_WIDTH         = 16;
  localparam int BEAT_CNT_WIDTH    = $clog2(NUMBER_PACKET);

  localparam logic [7:0] SOP_MAGIC = 8'hA5;
  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(NUMBER_PACKET - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } asm_state_t;

  function automatic logic is_header(input logic [AURORA_DATA_WIDTH-1:0] beat);
    return beat[AURORA_DATA_WIDTH-1 -: 8] == SOP_MAGIC;
  endfunction

endpackage

// File: rtl/router_aurora_rx_assembler_if.sv
// Aurora RX beat stream plus packet FIFO write side, bundled for the assembler.
interface router_aurora_rx_assembler_if;
  import router_pkg::*;

  logic [AURORA_DATA_WIDTH-1:0] rx_tdata;
  logic                         rx_tvalid;
  logic                         rx_tlast;
  logic                         full_pkt_fifo;
  logic                         write_pkt_fifo;
  logic [PKT_WIDTH-1:0]         pkt_fifo_wdata;

  modport master (
    output rx_tdata, rx_tvalid, rx_tlast, full_pkt_fifo,
    input  write_pkt_fifo, pkt_fifo_wdata
  );

  modport slave (
    input  rx_tdata, rx_tvalid, rx_tlast, full_pkt_fifo,
    output write_pkt_fifo, pkt_fifo_wdata
  );

endinterface

// File: rtl/router_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module router_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/router_aurora_rx_assembler.sv
// Assembles Aurora RX beats into checked packet words and hands them to the
// packet FIFO through a single holding register; Aurora cannot be stalled.
module router_aurora_rx_assembler
  import router_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  router_aurora_rx_assembler_if.slave bus,
  output logic                       pkt_err,
  output logic                       pkt_drop,
  output logic [CNT_WIDTH-1:0]       pkt_ok_cnt,
  output logic [CNT_WIDTH-1:0]       pkt_err_cnt,
  output logic [CNT_WIDTH-1:0]       pkt_drop_cnt
);

  localparam int W = AURORA_DATA_WIDTH;

  asm_state_t                state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [W-1:0]              csum_q, csum_d;
  logic [PKT_WIDTH-1:0]      asm_q, asm_d;
  logic [PKT_WIDTH-1:0]      hold_q, hold_d;
  logic                      hold_valid_q, hold_valid_d;
  logic                      err_d, drop_d, complete, fifo_write;

  assign fifo_write          = hold_valid_q & ~bus.full_pkt_fifo;
  assign bus.write_pkt_fifo  = fifo_write;
  assign bus.pkt_fifo_wdata  = hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      csum_q       <= '0;
      asm_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      pkt_err      <= 1'b0;
      pkt_drop     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      csum_q       <= csum_d;
      asm_q        <= asm_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      pkt_err      <= err_d;
      pkt_drop     <= drop_d;
    end
  end

  // Beats only move the FSM when valid; gaps inside a frame just hold state.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    csum_d     = csum_q;
    asm_d      = asm_q;
    err_d      = 1'b0;
    complete   = 1'b0;

    if (bus.rx_tvalid) begin
      unique case (state_q)
        IDLE: begin
          if (is_header(bus.rx_tdata)) begin
            if (bus.rx_tlast) begin
              err_d = 1'b1;
            end else begin
              asm_d[0 +: W] = bus.rx_tdata;
              beat_cnt_d    = BEAT_CNT_WIDTH'(1);
              csum_d        = bus.rx_tdata;
              state_d       = COLLECT;
            end
          end else begin
            err_d = 1'b1;
            if (!bus.rx_tlast) state_d = DISCARD;
          end
        end
        COLLECT: begin
          if (!bus.rx_tlast) begin
            if (beat_cnt_q != LAST_BEAT) begin
              asm_d[int'(beat_cnt_q)*W +: W] = bus.rx_tdata;
              beat_cnt_d = beat_cnt_q + BEAT_CNT_WIDTH'(1);
              csum_d     = csum_q ^ bus.rx_tdata;
            end else begin
              err_d      = 1'b1;
              beat_cnt_d = '0;
              state_d    = DISCARD;
            end
          end else begin
            asm_d[int'(beat_cnt_q)*W +: W] = bus.rx_tdata;
            if ((beat_cnt_q == LAST_BEAT) && (bus.rx_tdata == csum_q)) begin
              complete = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            beat_cnt_d = '0;
            state_d    = IDLE;
          end
        end
        DISCARD: begin
          if (bus.rx_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A finished packet may take the holding slot if it is empty or draining
  // this very cycle; otherwise the new packet is dropped whole.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    drop_d       = 1'b0;

    if (fifo_write) hold_valid_d = 1'b0;

    if (complete) begin
      if (!hold_valid_q || fifo_write) begin
        hold_d       = asm_d;
        hold_valid_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  router_sat_counter #(.WIDTH(CNT_WIDTH)) u_ok_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fifo_write),
    .count (pkt_ok_cnt)
  );

  router_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pkt_err),
    .count (pkt_err_cnt)
  );

  router_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pkt_drop),
    .count (pkt_drop_cnt)
  );

endmodule
